// File: rtl/seq_detector_if.sv
// Serial pattern-detector bus: data/config from the master, match status back from the detector.
interface seq_detector_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned ST_W = $clog2(PAT_W + 1);

  logic             In;
  logic             InValid;
  logic [PAT_W-1:0] Pattern;
  logic             Overlap;
  logic             Clear;
  logic             Out;
  logic [ST_W-1:0]  State;
  logic [CNT_W-1:0] MatchCount;

  modport master (
    output In, InValid, Pattern, Overlap, Clear,
    input  Out, State, MatchCount
  );

  modport slave (
    input  In, InValid, Pattern, Overlap, Clear,
    output Out, State, MatchCount
  );
endinterface

// File: rtl/seq_detector.sv
// Serial bit-pattern detector with fill tracking and optional saturating match counter.
// Define SEQ_DETECTOR_COUNT_EN to build the match counter; otherwise MatchCount is tied to 0.
module seq_detector #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  seq_detector_if.slave bus
);
  localparam int unsigned ST_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] window_q, window_d;
  logic [ST_W-1:0]  state_q,  state_d;
  logic             out_q,    out_d;
  logic [PAT_W-1:0] shifted_c;
  logic             match_c;

  // Newest bit enters at the top; window[0] is the oldest.
  assign shifted_c = {bus.In, window_q[PAT_W-1:1]};
  assign match_c   = bus.InValid && (state_q >= ST_W'(PAT_W - 1)) && (shifted_c == bus.Pattern);

  always_comb begin
    window_d = window_q;
    state_d  = state_q;
    out_d    = match_c;
    if (bus.InValid) begin
      window_d = shifted_c;
      if (match_c && !bus.Overlap) begin
        state_d = '0;
      end else if (state_q != ST_W'(PAT_W)) begin
        state_d = state_q + ST_W'(1);
      end
    end
  end

  // Reset beats Clear, Clear beats any match on the same edge.
  always_ff @(posedge Clock) begin
    if (Reset || bus.Clear) begin
      window_q <= '0;
      state_q  <= '0;
      out_q    <= 1'b0;
    end else begin
      window_q <= window_d;
      state_q  <= state_d;
      out_q    <= out_d;
    end
  end

  assign bus.Out   = out_q;
  assign bus.State = state_q;

`ifdef SEQ_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating: hold at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (match_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || bus.Clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.MatchCount = cnt_q;
`else
  assign bus.MatchCount = CNT_W'(0);
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Directed self-checking bench for seq_detector (PAT_W=4, CNT_W=2).
module tb_seq_detector;
  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_detector_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) sif ();

  seq_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (sif.slave)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected counter value after n matches since the last clear.
  function automatic int exp_cnt(input int n);
`ifdef SEQ_DETECTOR_COUNT_EN
    return (n > 3) ? 3 : n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic drive(input logic b, input logic v);
    @(negedge clk);
    sif.In      = b;
    sif.InValid = v;
    @(posedge clk);
    #1;
    sif.InValid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    sif.Clear = 1'b1;
    @(posedge clk);
    #1;
    sif.Clear = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Feed n valid bits (bits[0] first) and check Out after each against outs[i].
  task automatic run_seq(input string tag, input logic [7:0] bits, input logic [7:0] outs, input int n);
    for (int i = 0; i < n; i++) begin
      drive(bits[i], 1'b1);
      check($sformatf("%s_out%0d", tag, i), int'(sif.Out), int'(outs[i]));
    end
  endtask

  initial begin
    sif.In      = 1'b0;
    sif.InValid = 1'b0;
    sif.Pattern = 4'b1011;
    sif.Overlap = 1'b0;
    sif.Clear   = 1'b0;
    rst         = 1'b0;

    do_reset();
    check("rst_out",   int'(sif.Out), 0);
    check("rst_state", int'(sif.State), 0);
    check("rst_cnt",   int'(sif.MatchCount), 0);

    // Basic match: 1,1,0,1 against 1011
    run_seq("basic", 8'h0B, 8'h08, 4);
    check("basic_state", int'(sif.State), 0);
    check("basic_cnt",   int'(sif.MatchCount), exp_cnt(1));
    drive(1'b0, 1'b0);
    check("basic_pulse_end", int'(sif.Out), 0);

    // Overlap on: 1,0,1,0,1,0 against 0101 -> pulses after bits 4 and 6
    do_clear();
    check("clr_cnt", int'(sif.MatchCount), 0);
    sif.Pattern = 4'b0101;
    sif.Overlap = 1'b1;
    run_seq("ovl1", 8'h15, 8'h28, 6);
    check("ovl1_state", int'(sif.State), 4);
    check("ovl1_cnt",   int'(sif.MatchCount), exp_cnt(2));

    // Overlap off: same stream, single pulse
    do_clear();
    sif.Overlap = 1'b0;
    run_seq("ovl0", 8'h15, 8'h08, 6);
    check("ovl0_state", int'(sif.State), 2);
    check("ovl0_cnt",   int'(sif.MatchCount), exp_cnt(1));

    // Gaps: InValid low for 3 cycles between bits 2 and 3
    do_clear();
    sif.Pattern = 4'b1011;
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    for (int g = 0; g < 3; g++) begin
      drive(1'b0, 1'b0);
      check($sformatf("gap_state%0d", g), int'(sif.State), 2);
      check($sformatf("gap_out%0d", g),   int'(sif.Out), 0);
    end
    drive(1'b0, 1'b1);
    check("gap_out3", int'(sif.Out), 0);
    drive(1'b1, 1'b1);
    check("gap_match", int'(sif.Out), 1);
    check("gap_state", int'(sif.State), 0);
    check("gap_cnt",   int'(sif.MatchCount), exp_cnt(1));

    // Reset mid-stream discards partial sequence
    do_clear();
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    do_reset();
    check("midrst_state0", int'(sif.State), 0);
    drive(1'b1, 1'b1);
    check("midrst_out",   int'(sif.Out), 0);
    check("midrst_state", int'(sif.State), 1);
    check("midrst_cnt",   int'(sif.MatchCount), 0);

    // Saturation: five non-overlapping matches, CNT_W=2
    do_clear();
    for (int m = 1; m <= 5; m++) begin
      run_seq($sformatf("sat%0d", m), 8'h0B, 8'h08, 4);
      check($sformatf("sat_cnt%0d", m), int'(sif.MatchCount), exp_cnt(m));
    end

    // Clear collides with the completing bit
    do_clear();
    run_seq("pre", 8'h0B, 8'h08, 4);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    @(negedge clk);
    sif.In      = 1'b1;
    sif.InValid = 1'b1;
    sif.Clear   = 1'b1;
    @(posedge clk);
    #1;
    sif.InValid = 1'b0;
    sif.Clear   = 1'b0;
    check("coll_out",   int'(sif.Out), 0);
    check("coll_state", int'(sif.State), 0);
    check("coll_cnt",   int'(sif.MatchCount), 0);
    drive(1'b0, 1'b0);
    check("coll_out_next", int'(sif.Out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
